matmul_mac_scheduler: RTL



---
 rtl/matmul_mac_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/matmul_mac_scheduler.sv
// NxN integer matrix multiply sequenced through one shared external multiplier; C streams out row-major.
// Optional MAC_MUL_REG_EN registers the product before the accumulator (one extra MAC cycle).
module matmul_mac_scheduler #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inWrEn,
  input  logic                      inWrSel,
  input  logic [2*$clog2(N)-1:0]    inWrAddr,
  input  logic [DATA_WIDTH/2-1:0]   inWrData,
  input  logic                      inStart,
  output logic                      outBusy,
  output logic                      outDone,
  output logic [DATA_WIDTH/2-1:0]   mulA,
  output logic [DATA_WIDTH/2-1:0]   mulB,
  input  logic [DATA_WIDTH-1:0]     mulC,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [ACC_WIDTH-1:0]      outData,
  output logic [2*$clog2(N)-1:0]    outIdx
);
  localparam int OW = DATA_WIDTH / 2;
  localparam int LN = $clog2(N);
  localparam int AW = 2 * LN;
  localparam int CW = 3 * LN;
  localparam int NN = N * N;
  localparam logic [LN-1:0] K_LAST   = '1;
  localparam logic [AW-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2, S_DONE = 2'd3} state_t;

  logic [OW-1:0]        a_mem [NN];
  logic [OW-1:0]        b_mem [NN];
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 iss_end_q;
  logic [LN-1:0]        iss_i, iss_j, iss_k;
  logic                 vld_p0;
  logic [CW-1:0]        tag_p0;
`ifdef MAC_MUL_REG_EN
  logic                 vld_p1;
  logic [CW-1:0]        tag_p1;
  logic [DATA_WIDTH-1:0] prod_p1;
`endif
  logic                 acc_vld;
  logic [CW-1:0]        acc_tag;
  logic [DATA_WIDTH-1:0] acc_prod;
  logic [ACC_WIDTH-1:0] acc_q, acc_base, acc_sum;
  logic [ACC_WIDTH-1:0] c_q [NN];
  logic                 busy_q, done_q, valid_q;
  logic [OW-1:0]        mula_q, mulb_q;
  logic [ACC_WIDTH-1:0] data_q;
  logic [AW-1:0]        idx_q;

  function automatic logic [ACC_WIDTH-1:0] zext(input logic [DATA_WIDTH-1:0] p);
    return ACC_WIDTH'(p);
  endfunction

  // {i,j,k} packed into one counter so k runs fastest, then j, then i
  assign iss_i = cnt_q[CW-1:AW];
  assign iss_j = cnt_q[AW-1:LN];
  assign iss_k = cnt_q[LN-1:0];

  assign outBusy  = busy_q;
  assign outDone  = done_q;
  assign outValid = valid_q;
  assign mulA     = mula_q;
  assign mulB     = mulb_q;
  assign outData  = data_q;
  assign outIdx   = idx_q;

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && inWrEn) begin
      if (inWrSel) b_mem[inWrAddr] <= inWrData;
      else         a_mem[inWrAddr] <= inWrData;
    end
  end

  always_comb begin
`ifdef MAC_MUL_REG_EN
    acc_vld  = vld_p1;
    acc_tag  = tag_p1;
    acc_prod = prod_p1;
`else
    acc_vld  = vld_p0;
    acc_tag  = tag_p0;
    acc_prod = mulC;
`endif
    acc_base = (acc_tag[LN-1:0] == '0) ? '0 : acc_q;
    acc_sum  = acc_base + zext(acc_prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      iss_end_q <= 1'b0;
      vld_p0    <= 1'b0;
      tag_p0    <= '0;
`ifdef MAC_MUL_REG_EN
      vld_p1    <= 1'b0;
      tag_p1    <= '0;
      prod_p1   <= '0;
`endif
      acc_q     <= '0;
      for (int n = 0; n < NN; n++) c_q[n] <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      mula_q    <= '0;
      mulb_q    <= '0;
      data_q    <= '0;
      idx_q     <= '0;
    end else begin
      mula_q <= '0;
      mulb_q <= '0;
      vld_p0 <= 1'b0;
      done_q <= 1'b0;
`ifdef MAC_MUL_REG_EN
      // product stage: capture mulC one cycle after issue
      vld_p1  <= vld_p0;
      tag_p1  <= tag_p0;
      prod_p1 <= mulC;
`endif
      // accumulate stage
      if (acc_vld) begin
        acc_q <= acc_sum;
        if (acc_tag[LN-1:0] == K_LAST) c_q[acc_tag[CW-1:LN]] <= acc_sum;
      end
      case (state_q)
        S_IDLE: begin
          if (inStart) begin
            state_q   <= S_MAC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            iss_end_q <= 1'b0;
          end
        end
        S_MAC: begin
          if (!iss_end_q) begin
            mula_q <= a_mem[{iss_i, iss_k}];
            mulb_q <= b_mem[{iss_k, iss_j}];
            vld_p0 <= 1'b1;
            tag_p0 <= cnt_q;
            cnt_q  <= cnt_q + CW'(1);
            if (&cnt_q) iss_end_q <= 1'b1;
          end
          // the final product's accumulate also writes the last C element
          if (acc_vld && (&acc_tag)) begin
            state_q <= S_OUT;
            valid_q <= 1'b1;
            idx_q   <= '0;
            data_q  <= c_q[0];
          end
        end
        S_OUT: begin
          if (outReady) begin
            if (idx_q == IDX_LAST) begin
              valid_q <= 1'b0;
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q  <= idx_q + AW'(1);
              data_q <= c_q[idx_q + AW'(1)];
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
